// File: rtl/mimd_io_arbiter_if.sv
// Core-side handshake bundle for mimd_io_arbiter: input-word and output-word request/ack channels.
// master = core array, slave = arbiter.
interface mimd_io_arbiter_if #(
   parameter int N_CORES = 4,
   parameter int DATA_W  = 16
);
   logic [N_CORES-1:0]        in_req;
   logic [N_CORES-1:0]        in_ack;
   logic [DATA_W-1:0]         in_data;
   logic [N_CORES-1:0]        out_req;
   logic [N_CORES*DATA_W-1:0] out_wdata;
   logic [N_CORES-1:0]        out_ack;

   modport master (
      output in_req, out_req, out_wdata,
      input  in_ack, in_data, out_ack
   );

   modport slave (
      input  in_req, out_req, out_wdata,
      output in_ack, in_data, out_ack
   );
endinterface

// File: rtl/mimd_io_arbiter.sv
// Shares board SW/Button I/O between N_CORES cores with debounced buttons and round-robin grants.
// Optional IO_ARB_OVERRUN_FLAG_EN adds a sticky in_overrun flag for presses dropped while an input is pending.
module mimd_io_arbiter #(
   parameter int N_CORES         = 4,
   parameter int DATA_W          = 16,
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic [9:0]        SW,
   input  logic [1:0]        Button,
   mimd_io_arbiter_if.slave  io,
   output logic [DATA_W-1:0] disp_value,
   output logic              in_pending,
   output logic              out_full
`ifdef IO_ARB_OVERRUN_FLAG_EN
   ,
   output logic              in_overrun
`endif
);

   localparam int PTR_W = $clog2(N_CORES);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic {IN_IDLE, IN_PEND} in_state_e;
   typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

   logic [1:0]            meta_q, sync_q, press_q;
   logic [1:0][CNT_W-1:0] cnt_q;

   in_state_e             in_state_q;
   out_state_e            out_state_q;
   logic [PTR_W-1:0]      in_ptr_q, out_ptr_q;
   logic [PTR_W-1:0]      in_grant, out_grant;
   logic [N_CORES-1:0]    in_ack_q, out_ack_q;
   logic [DATA_W-1:0]     in_data_q, held_q, disp_q;

   // First requester at or after ptr, wrapping N_CORES-1 -> 0.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [N_CORES-1:0] req,
                                                input logic [PTR_W-1:0]   ptr);
      logic [PTR_W-1:0] pick;
      logic             found;
      int               idx;
      // NOTE: every local gets a value before the loop, so no path leaves one unassigned (no latch).
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < N_CORES; k++) begin
         idx = (int'(ptr) + k) % N_CORES;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = PTR_W'(idx);
         end
      end
      return pick;
   endfunction

   function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] g);
      return (int'(g) == N_CORES - 1) ? '0 : g + 1'b1;
   endfunction

   assign in_grant  = rr_pick(io.in_req, in_ptr_q);
   assign out_grant = rr_pick(io.out_req, out_ptr_q);

   // Counter saturates at DEBOUNCE_CYCLES so a held button yields a single pulse.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         meta_q  <= '0;
         sync_q  <= '0;
         cnt_q   <= '0;
         press_q <= '0;
      end else begin
         // NOTE: non-blocking (<=) here so every register samples its pre-edge inputs.
         meta_q <= Button;
         sync_q <= meta_q;
         for (int b = 0; b < 2; b++) begin
            if (!sync_q[b])
               cnt_q[b] <= '0;
            else if (cnt_q[b] != CNT_W'(DEBOUNCE_CYCLES))
               cnt_q[b] <= cnt_q[b] + 1'b1;
            press_q[b] <= sync_q[b] && (cnt_q[b] == CNT_W'(DEBOUNCE_CYCLES - 1));
         end
      end
   end

`ifdef IO_ARB_OVERRUN_FLAG_EN
   logic in_overrun_q;
`endif

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         in_state_q   <= IN_IDLE;
         in_ptr_q     <= '0;
         in_ack_q     <= '0;
         in_data_q    <= '0;
`ifdef IO_ARB_OVERRUN_FLAG_EN
         in_overrun_q <= 1'b0;
`endif
      end else begin
         in_ack_q <= '0;
         case (in_state_q)
            IN_IDLE: if (press_q[0]) begin
               in_data_q  <= DATA_W'(SW);
               in_state_q <= IN_PEND;
            end
            IN_PEND: if (|io.in_req) begin
               in_ack_q[in_grant] <= 1'b1;
               in_ptr_q           <= rr_next(in_grant);
               in_state_q         <= IN_IDLE;
            end
            default: in_state_q <= IN_IDLE;
         endcase
`ifdef IO_ARB_OVERRUN_FLAG_EN
         if (press_q[0] && in_state_q == IN_PEND)
            in_overrun_q <= 1'b1;
`endif
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         out_state_q <= OUT_EMPTY;
         out_ptr_q   <= '0;
         out_ack_q   <= '0;
         // NOTE: the held word is reset as well, so a bad state can never leak X onto the display.
         held_q      <= '0;
         disp_q      <= '0;
      end else begin
         out_ack_q <= '0;
         case (out_state_q)
            OUT_EMPTY: begin
               if (press_q[1])
                  disp_q <= '0;
               if (|io.out_req) begin
                  held_q               <= io.out_wdata[int'(out_grant)*DATA_W +: DATA_W];
                  out_ack_q[out_grant] <= 1'b1;
                  out_ptr_q            <= rr_next(out_grant);
                  out_state_q          <= OUT_FULL;
               end
            end
            // A press wins over new offers; the next grant comes from EMPTY a cycle later.
            OUT_FULL: if (press_q[1]) begin
               disp_q      <= held_q;
               out_state_q <= OUT_EMPTY;
            end
            default: out_state_q <= OUT_EMPTY;
         endcase
      end
   end

   assign io.in_ack   = in_ack_q;
   assign io.in_data  = in_data_q;
   assign io.out_ack  = out_ack_q;
   assign disp_value  = disp_q;
   assign in_pending  = (in_state_q == IN_PEND);
   assign out_full    = (out_state_q == OUT_FULL);
`ifdef IO_ARB_OVERRUN_FLAG_EN
   assign in_overrun  = in_overrun_q;
`endif

endmodule

// File: tb/tb_mimd_io_arbiter.sv
// Directed scoreboard bench for mimd_io_arbiter (DEBOUNCE_CYCLES=4); expected acks are queued
// when stimulus is driven and popped when the DUT pulses an ack.
module tb_mimd_io_arbiter;
   localparam int N = 4;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [9:0]    sw = '0;
   logic [1:0]    button = '0;
   logic [W-1:0]  disp_value;
   logic          in_pending;
   logic          out_full;
`ifdef IO_ARB_OVERRUN_FLAG_EN
   logic          in_overrun;
`endif

   mimd_io_arbiter_if #(.N_CORES(N), .DATA_W(W)) io();

   mimd_io_arbiter #(.N_CORES(N), .DATA_W(W), .DEBOUNCE_CYCLES(4)) dut (
      .Clock      (clk),
      .nReset     (rst_n),
      .SW         (sw),
      .Button     (button),
      .io         (io),
      .disp_value (disp_value),
      .in_pending (in_pending),
      .out_full   (out_full)
`ifdef IO_ARB_OVERRUN_FLAG_EN
      ,
      .in_overrun (in_overrun)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] ack;
      logic [W-1:0] data;
   } in_exp_t;

   in_exp_t      in_q[$];
   logic [N-1:0] out_q[$];
   int           n_pass = 0;
   int           n_total = 0;
   logic         pend_seen = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One cycle: sample at negedge, score any ack, and let the acked core drop its request.
   task automatic tick();
      in_exp_t      e;
      logic [N-1:0] oe;
      @(negedge clk);
      if (in_pending === 1'b1) pend_seen = 1'b1;
      if (io.in_ack !== '0) begin
         if (in_q.size() == 0) begin
            check("in_ack_unexpected", 32'(io.in_ack), 32'd0);
         end else begin
            e = in_q.pop_front();
            check("in_ack", 32'(io.in_ack), 32'(e.ack));
            check("in_data", 32'(io.in_data), 32'(e.data));
         end
         io.in_req = io.in_req & ~io.in_ack;
      end
      if (io.out_ack !== '0) begin
         if (out_q.size() == 0) begin
            check("out_ack_unexpected", 32'(io.out_ack), 32'd0);
         end else begin
            oe = out_q.pop_front();
            check("out_ack", 32'(io.out_ack), 32'(oe));
         end
         io.out_req = io.out_req & ~io.out_ack;
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 60 && (in_q.size() + out_q.size()) > 0; i++) tick();
      check(tag, 32'(in_q.size() + out_q.size()), 32'd0);
   endtask

   task automatic press(input int b, input int hold);
      button[b] = 1'b1;
      repeat (hold) tick();
      button[b] = 1'b0;
      repeat (4) tick();
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      io.in_req  = '0;
      io.out_req = '0;
      button     = '0;
      in_q.delete();
      out_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      io.in_req    = '0;
      io.out_req   = '0;
      io.out_wdata = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_in_ack",     32'(io.in_ack),   32'd0);
      check("rst_out_ack",    32'(io.out_ack),  32'd0);
      check("rst_in_data",    32'(io.in_data),  32'd0);
      check("rst_disp",       32'(disp_value),  32'd0);
      check("rst_in_pending", 32'(in_pending),  32'd0);
      check("rst_out_full",   32'(out_full),    32'd0);
`ifdef IO_ARB_OVERRUN_FLAG_EN
      check("rst_overrun",    32'(in_overrun),  32'd0);
`endif
      rst_n = 1'b1;
      tick();

      // 1: capture SW=3 and hand it to core 0
      sw        = 10'd3;
      io.in_req = 4'b0001;
      in_q.push_back('{4'b0001, 16'd3});
      pend_seen = 1'b0;
      press(0, 10);
      drain("t1_drain");
      check("t1_pending_seen", 32'(pend_seen),  32'd1);
      check("t1_pending_clr",  32'(in_pending), 32'd0);
      check("t1_data_hold",    32'(io.in_data), 32'd3);

      // 2: core 2 offers 5, shown on press, then cleared by a press in EMPTY
      io.out_wdata[2*W +: W] = 16'h0005;
      io.out_req = 4'b0100;
      out_q.push_back(4'b0100);
      drain("t2_drain");
      check("t2_full", 32'(out_full), 32'd1);
      press(1, 10);
      check("t2_disp",     32'(disp_value), 32'h5);
      check("t2_full_clr", 32'(out_full),   32'd0);
      press(1, 10);
      check("t2_disp_zero", 32'(disp_value), 32'd0);

      // 3: all four cores offer, round-robin from a fresh pointer
      do_reset();
      for (int i = 0; i < N; i++) io.out_wdata[i*W +: W] = W'(i + 1);
      out_q.push_back(4'b0001);
      io.out_req = 4'b1111;
      drain("t3_first");
      for (int k = 0; k < N; k++) begin
         if (k < N - 1) out_q.push_back(N'(1) << (k + 1));
         press(1, 10);
         drain("t3_grant");
         check("t3_disp", 32'(disp_value), 32'(k + 1));
      end
      press(1, 10);
      check("t3_disp_end", 32'(disp_value), 32'd0);
      check("t3_full_end", 32'(out_full),   32'd0);

      // 4: short glitch ignored, long hold gives exactly one capture
      sw = 10'd9;
      button[0] = 1'b1;
      repeat (2) tick();
      button[0] = 1'b0;
      repeat (10) tick();
      check("t4_glitch_pending", 32'(in_pending), 32'd0);
      check("t4_glitch_data",    32'(io.in_data), 32'd0);
      io.in_req = 4'b0001;
      in_q.push_back('{4'b0001, 16'd9});
      press(0, 100);
      drain("t4_drain");
      check("t4_single_capture", 32'(in_pending), 32'd0);
      check("t4_data",           32'(io.in_data), 32'd9);

      // 5: second press while pending is dropped
      io.in_req = '0;
      sw = 10'd6;
      press(0, 10);
      check("t5_pending", 32'(in_pending), 32'd1);
      sw = 10'd7;
      press(0, 10);
      check("t5_data_kept", 32'(io.in_data), 32'd6);
`ifdef IO_ARB_OVERRUN_FLAG_EN
      check("t5_overrun", 32'(in_overrun), 32'd1);
`endif
      io.in_req = 4'b0010;
      in_q.push_back('{4'b0010, 16'd6});
      drain("t5_drain");
      check("t5_pending_clr", 32'(in_pending), 32'd0);

      // 6: asynchronous reset while PEND and FULL
      sw = 10'd5;
      press(0, 10);
      io.out_wdata[1*W +: W] = 16'h0008;
      io.out_req = 4'b0010;
      out_q.push_back(4'b0010);
      drain("t6_out1");
      press(1, 10);
      check("t6_disp", 32'(disp_value), 32'h8);
      io.out_wdata[3*W +: W] = 16'h000A;
      io.out_req = 4'b1000;
      out_q.push_back(4'b1000);
      drain("t6_out2");
      check("t6_pending_pre", 32'(in_pending), 32'd1);
      check("t6_full_pre",    32'(out_full),   32'd1);

      @(posedge clk);
      #2;
      rst_n      = 1'b0;
      io.in_req  = '0;
      io.out_req = '0;
      #1;
      check("t6_async_in_ack",  32'(io.in_ack),  32'd0);
      check("t6_async_out_ack", 32'(io.out_ack), 32'd0);
      check("t6_async_in_data", 32'(io.in_data), 32'd0);
      check("t6_async_disp",    32'(disp_value), 32'd0);
      check("t6_async_pending", 32'(in_pending), 32'd0);
      check("t6_async_full",    32'(out_full),   32'd0);
`ifdef IO_ARB_OVERRUN_FLAG_EN
      check("t6_async_overrun", 32'(in_overrun), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) tick();
      check("t6_idle_pending", 32'(in_pending), 32'd0);
      check("t6_idle_full",    32'(out_full),   32'd0);

      // Recovery after reset: fresh request is served from pointer 0
      sw = 10'h2A;
      io.in_req = 4'b0100;
      in_q.push_back('{4'b0100, 16'h002A});
      press(0, 10);
      drain("t6_recover");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
